// File: rtl/fifo_buffer.sv
// Single-clock FIFO with registered read data and full/empty flags.
// Storage is a plain register array; only pointers, count and read data are reset.
module fifo_buffer #(
  parameter int unsigned DATA_WIDTH        = 32,
  parameter int unsigned BUFFER_ADDR_WIDTH = 5
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic [DATA_WIDTH-1:0] data_i,
  input  logic                  rden_i,
  input  logic                  wren_i,
  output logic [DATA_WIDTH-1:0] data_o,
  output logic                  empty_o,
  output logic                  full_o
);

  localparam int unsigned Depth = 1 << BUFFER_ADDR_WIDTH;
  localparam logic [BUFFER_ADDR_WIDTH:0] DepthCnt = (BUFFER_ADDR_WIDTH + 1)'(Depth);

  logic [DATA_WIDTH-1:0]        mem_q [Depth];
  logic [BUFFER_ADDR_WIDTH-1:0] wr_ptr_q, wr_ptr_d;
  logic [BUFFER_ADDR_WIDTH-1:0] rd_ptr_q, rd_ptr_d;
  logic [BUFFER_ADDR_WIDTH:0]   count_q, count_d;
  logic [DATA_WIDTH-1:0]        data_q, data_d;
  logic                         rd_ok, wr_ok;

  assign empty_o = (count_q == '0);
  assign full_o  = (count_q == DepthCnt);
  assign data_o  = data_q;

  // A read frees a slot on the same edge, so a full FIFO still accepts a paired write.
  assign rd_ok = rden_i & ~empty_o;
  assign wr_ok = wren_i & (~full_o | rd_ok);

  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    data_d   = data_q;
    if (wr_ok) begin
      wr_ptr_d = wr_ptr_q + 1'b1;
    end
    if (rd_ok) begin
      rd_ptr_d = rd_ptr_q + 1'b1;
      data_d   = mem_q[rd_ptr_q];
    end
    unique case ({wr_ok, rd_ok})
      2'b10:   count_d = count_q + 1'b1;
      2'b01:   count_d = count_q - 1'b1;
      default: count_d = count_q;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
      data_q   <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
      data_q   <= data_d;
    end
  end

  always_ff @(posedge clk) begin
    if (wr_ok) begin
      mem_q[wr_ptr_q] <= data_i;
    end
  end

endmodule

// File: tb/tb_fifo_buffer.sv
// Scoreboard bench for fifo_buffer: a queue model predicts read data and flags each cycle.
module tb_fifo_buffer;

  localparam int unsigned DW    = 36;
  localparam int unsigned AW    = 5;
  localparam int unsigned Depth = 1 << AW;

  logic          clk = 1'b0;
  logic          reset = 1'b1;
  logic [DW-1:0] data_i = '0;
  logic          rden_i = 1'b0;
  logic          wren_i = 1'b0;
  logic [DW-1:0] data_o;
  logic          empty_o;
  logic          full_o;

  int total = 0;
  int bad   = 0;

  logic [DW-1:0] model_q [$];
  logic [DW-1:0] exp_q   [$];
  logic [DW-1:0] last_data = '0;

  fifo_buffer #(
    .DATA_WIDTH       (DW),
    .BUFFER_ADDR_WIDTH(AW)
  ) u_dut (
    .clk    (clk),
    .reset  (reset),
    .data_i (data_i),
    .rden_i (rden_i),
    .wren_i (wren_i),
    .data_o (data_o),
    .empty_o(empty_o),
    .full_o (full_o)
  );

  always #5 clk = ~clk;

  task automatic check_val(input string tag, input logic [63:0] obs, input logic [63:0] expv);
    total++;
    if (obs !== expv) begin
      bad++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, expv);
    end
  endtask

  task automatic check_flags(input string tag);
    check_val({tag, ".empty"}, 64'(empty_o), 64'(model_q.size() == 0));
    check_val({tag, ".full"}, 64'(full_o), 64'(model_q.size() == Depth));
  endtask

  // One clock: drive at negedge, update model, sample 1ns after the rising edge.
  task automatic cycle(input string tag, input logic wr, input logic rd, input logic [DW-1:0] d);
    logic rd_ok, wr_ok;
    @(negedge clk);
    wren_i = wr;
    rden_i = rd;
    data_i = d;
    rd_ok = rd && (model_q.size() > 0);
    wr_ok = wr && ((model_q.size() < Depth) || rd_ok);
    if (rd_ok) exp_q.push_back(model_q.pop_front());
    if (wr_ok) model_q.push_back(d);
    @(posedge clk);
    #1;
    if (rd_ok) last_data = exp_q.pop_front();
    check_val({tag, ".data"}, 64'(data_o), 64'(last_data));
    check_flags(tag);
    wren_i = 1'b0;
    rden_i = 1'b0;
  endtask

  function automatic logic [DW-1:0] rnd();
    logic [DW-1:0] v;
    v = {4'($urandom), 32'($urandom)};
    return v;
  endfunction

  initial begin
    // Power-on reset held for two edges.
    reset = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    check_val("rst.data", 64'(data_o), 64'h0);
    check_val("rst.empty", 64'(empty_o), 64'h1);
    check_val("rst.full", 64'(full_o), 64'h0);
    @(negedge clk);
    reset = 1'b0;

    cycle("wr1", 1'b1, 1'b0, 36'h9_1234_5678);
    cycle("rd1", 1'b0, 1'b1, '0);
    check_val("rd1.lit", 64'(data_o), 64'h9_1234_5678);

    for (int t = 0; t < 5; t++) begin
      for (int w = 0; w < 3; w++) begin
        cycle("rnd.wr", 1'b1, 1'b0, rnd());
        cycle("rnd.rd", 1'b0, 1'b1, '0);
      end
    end

    // Burst of three writes followed by three reads.
    for (int i = 0; i < 3; i++) cycle("burst.wr", 1'b1, 1'b0, rnd());
    for (int i = 0; i < 3; i++) cycle("burst.rd", 1'b0, 1'b1, '0);

    // Fill, overflow attempt, drain.
    for (int i = 0; i < Depth; i++) cycle("fill.wr", 1'b1, 1'b0, DW'(i));
    check_val("fill.full", 64'(full_o), 64'h1);
    cycle("fill.drop", 1'b1, 1'b0, DW'(8'hFF));
    for (int i = 0; i < Depth; i++) begin
      cycle("fill.rd", 1'b0, 1'b1, '0);
      check_val("fill.order", 64'(data_o), 64'(i));
    end

    // Read on empty holds data_o, even with a write on the same edge.
    cycle("empty.rd", 1'b0, 1'b1, '0);
    cycle("empty.rdwr", 1'b1, 1'b1, 36'h0_0000_0ABC);
    cycle("empty.rdwr.rd", 1'b0, 1'b1, '0);
    check_val("empty.rdwr.val", 64'(data_o), 64'hABC);

    // Simultaneous read/write at count 1.
    cycle("sim.wrX", 1'b1, 1'b0, 36'h1_1111_1111);
    cycle("sim.rdwr", 1'b1, 1'b1, 36'h2_2222_2222);
    check_val("sim.X", 64'(data_o), 64'h1_1111_1111);
    cycle("sim.rdY", 1'b0, 1'b1, '0);
    check_val("sim.Y", 64'(data_o), 64'h2_2222_2222);

    // Simultaneous read/write while full keeps it full.
    for (int i = 0; i < Depth; i++) cycle("full.wr", 1'b1, 1'b0, rnd());
    cycle("full.rdwr", 1'b1, 1'b1, rnd());
    for (int i = 0; i < Depth; i++) cycle("full.rd", 1'b0, 1'b1, '0);

    // Asynchronous reset mid-operation, checked before the next clock edge.
    for (int i = 0; i < 3; i++) cycle("mid.wr", 1'b1, 1'b0, rnd());
    cycle("mid.rd", 1'b0, 1'b1, '0);
    @(negedge clk);
    #2;
    reset = 1'b1;
    #1;
    model_q.delete();
    last_data = '0;
    check_val("mid.rst.data", 64'(data_o), 64'h0);
    check_val("mid.rst.empty", 64'(empty_o), 64'h1);
    check_flags("mid.rst");
    @(negedge clk);
    reset = 1'b0;
    cycle("mid.after", 1'b0, 1'b1, '0);

    // Pointer wrap-around.
    for (int i = 0; i < 40; i++) begin
      cycle("wrap.wr", 1'b1, 1'b0, rnd());
      cycle("wrap.rd", 1'b0, 1'b1, '0);
    end

    check_val("sb.drained", 64'(exp_q.size()), 64'h0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout: got running expected finished");
    $fatal(1, "timeout");
  end

endmodule
